gray_sobel_edge_detect: RTL and testbench
=========================================

# gray_sobel_edge_detect

Streaming 3x3 Sobel edge detector that consumes the 8-bit gray-scale pixel stream produced by the RGB-to-gray conversion stage, in raster order, one pixel per clock at most. It holds two line buffers and a 3x3 window, computes |Gx|+|Gy| saturated to 8 bits, and emits one edge-magnitude pixel per interior image position, (IMAGE_HEIGHT-2)*(IMAGE_WIDTH-2) per frame. Output feeds the result BRAM writer.

## Interface
- IMAGE_HEIGHT, 600, rows per frame (≥3)
- IMAGE_WIDTH, 450, pixels per row (≥3)
- DATA_COLOR_WIDTH, 8, gray pixel width
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_pixel valid this cycle; no backpressure, gaps allowed
- in_pixel  input  DATA_COLOR_WIDTH  gray pixel, raster order, row 0 col 0 first
- out_valid  output  1  one-cycle pulse per output pixel
- out_pixel  output  DATA_COLOR_WIDTH  edge magnitude, held between pulses
- out_last  output  1  high with out_valid on the final output pixel of a frame

## Operation
- Counters col (0..W-1), row (0..H-1) give the position of the next accepted pixel; advance only on in_valid. col wraps to 0 and row increments at W-1; at (H-1, W-1) both wrap to 0, so the next pixel starts a new frame.
- Line buffers lb1 (row r-1), lb2 (row r-2), depth IMAGE_WIDTH, indexed by col. On accepted pixel at col c: window shifts left, new right column = {top lb2[c], mid lb1[c], bottom in_pixel}; lb2[c]<=lb1[c]; lb1[c]<=in_pixel.
- Window valid when accepted pixel has row≥2 and col≥2; window is then centred at (row-1, col-1).
- Window pij: i = 0 top..2 bottom, j = 0 left..2 right (newest).
- Gx = (p02+2p12+p22) − (p00+2p10+p20); Gy = (p20+2p21+p22) − (p00+2p01+p02). Both signed 11-bit, range ±1020, no overflow.
- mag = |Gx| + |Gy|, unsigned 11-bit (max 2040); out_pixel = mag>255 ? 255 : mag.
- out_last flag travels with the window whose completing pixel was (H-1, W-1).
- Line buffers and window not cleared between frames or on reset; rows 0–1 of a new frame never produce output, so stale contents are harmless.

## Timing
- 3-stage pipeline, advancing every cycle regardless of in_valid; valid bits travel with data.
  - Edge ending cycle N (in_valid high): counters, line buffers, window, win_valid registered.
  - Edge ending N+1: Gx, Gy, valid, last registered.
  - Edge ending N+2: out_pixel, out_valid, out_last registered; visible in cycle N+3.
- Latency: 3 cycles from the completing input pixel to out_valid. Throughput: 1 pixel/cycle sustained.
- out_valid never high for two different windows in one cycle; gapped input yields gapped output with identical spacing.
- Reset values: out_valid=0, out_pixel=0, out_last=0, row=col=0, all pipeline valid bits 0.
- Reset mid-frame: in-flight results discarded (no out_valid in any cycle of or after reset until new qualifying pixels); the first in_valid after reset deasserts is pixel (0,0).
- Reset and in_valid in the same cycle: reset wins, pixel dropped.
- Frames may be back-to-back with no idle cycle; the output count per frame is exact.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1, in_pixel=0xFF -> out_valid=0, out_pixel=0, out_last=0 throughout; next pixel counted as (0,0).
- Flat frame, H=4, W=5, all pixels 100 -> exactly 6 out_valid pulses, all out_pixel=0, out_last only on 6th, 3 cycles after last input.
- Horizontal ramp, H=4, W=5, pixel=10*col -> 6 outputs, each 80 (Gx=80, Gy=0).
- Vertical step, H=4, W=5, cols 0–1 = 0, cols 2–4 = 200 -> per output row 255, 255, 0 (Gx=800 saturated).
- Gapped input: ramp frame with in_valid toggling every other cycle -> same 6 values, each out_valid exactly 3 cycles after its completing pixel.
- Back-to-back frames (flat 100, then ramp) then reset asserted mid-third-frame -> 6 zeros, then 6×80, each with out_last; no outputs from the aborted frame; a fresh frame after reset gives the correct 6 outputs.

Source files
------------

// File: rtl/gray_sobel_edge_detect.sv
// Streaming 3x3 Sobel edge detector: two line buffers feed a sliding window,
// then |Gx|+|Gy| is saturated to the pixel width. Three register stages deep.
module gray_sobel_edge_detect #(
  parameter int IMAGE_HEIGHT     = 600,
  parameter int IMAGE_WIDTH      = 450,
  parameter int DATA_COLOR_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [DATA_COLOR_WIDTH-1:0] in_pixel,
  output logic                        out_valid,
  output logic [DATA_COLOR_WIDTH-1:0] out_pixel,
  output logic                        out_last
);

  localparam int DW   = DATA_COLOR_WIDTH;
  localparam int GW   = DW + 3;
  localparam int CW   = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int RW   = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int MAXV = (1 << DW) - 1;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          accept;
  logic          at_col_end, at_row_end;

  logic [DW-1:0] lb1_q [IMAGE_WIDTH];
  logic [DW-1:0] lb2_q [IMAGE_WIDTH];
  logic [DW-1:0] win_q [3][3];
  logic          win_valid_q, win_valid_d;
  logic          win_last_q, win_last_d;

  logic signed [GW-1:0] p_s [3][3];
  logic signed [GW-1:0] gx_q, gx_d, gy_q, gy_d;
  logic                 g_valid_q, g_valid_d;
  logic                 g_last_q, g_last_d;

  logic [GW-1:0] abs_gx, abs_gy, mag;
  logic [DW-1:0] sat;
  logic [DW-1:0] out_pixel_q, out_pixel_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;

  always_comb begin
    accept     = in_valid && !reset;
    at_col_end = (col_q == CW'(IMAGE_WIDTH - 1));
    at_row_end = (row_q == RW'(IMAGE_HEIGHT - 1));
    col_d      = col_q;
    row_d      = row_q;
    if (accept) begin
      if (at_col_end) begin
        col_d = '0;
        row_d = at_row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    win_valid_d = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
    win_last_d  = accept && at_row_end && at_col_end;

    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        p_s[i][j] = $signed({3'b000, win_q[i][j]});
      end
    end
    gx_d = (p_s[0][2] + (p_s[1][2] <<< 1) + p_s[2][2])
         - (p_s[0][0] + (p_s[1][0] <<< 1) + p_s[2][0]);
    gy_d = (p_s[2][0] + (p_s[2][1] <<< 1) + p_s[2][2])
         - (p_s[0][0] + (p_s[0][1] <<< 1) + p_s[0][2]);
    g_valid_d = win_valid_q;
    g_last_d  = win_last_q;

    // magnitudes never exceed 1020 each, so the sum fits GW bits unsigned
    abs_gx = gx_q[GW-1] ? GW'(-gx_q) : GW'(gx_q);
    abs_gy = gy_q[GW-1] ? GW'(-gy_q) : GW'(gy_q);
    mag    = abs_gx + abs_gy;
    sat    = (mag > GW'(MAXV)) ? DW'(MAXV) : mag[DW-1:0];

    out_valid_d = g_valid_q;
    out_last_d  = g_valid_q && g_last_q;
    out_pixel_d = g_valid_q ? sat : out_pixel_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      g_valid_q   <= 1'b0;
      g_last_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_pixel_q <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      g_valid_q   <= g_valid_d;
      g_last_q    <= g_last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_pixel_q <= out_pixel_d;
    end
  end

  // Line buffers and window keep stale data across frames; rows 0-1 never qualify.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= in_pixel;
      for (int i = 0; i < 3; i++) begin
        win_q[i][0] <= win_q[i][1];
        win_q[i][1] <= win_q[i][2];
      end
      win_q[0][2] <= lb2_q[col_q];
      win_q[1][2] <= lb1_q[col_q];
      win_q[2][2] <= in_pixel;
    end
    gx_q <= gx_d;
    gy_q <= gy_d;
  end

  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_gray_sobel_edge_detect.sv
// Directed bench for gray_sobel_edge_detect on a 4x5 image with hand-computed results.
module tb_gray_sobel_edge_detect;

  localparam int H = 4;
  localparam int W = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_pixel;
  logic       out_valid;
  logic [7:0] out_pixel;
  logic       out_last;

  gray_sobel_edge_detect #(
    .IMAGE_HEIGHT(H),
    .IMAGE_WIDTH(W),
    .DATA_COLOR_WIDTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_pixel(in_pixel),
    .out_valid(out_valid),
    .out_pixel(out_pixel),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int fails  = 0;
  int edge_n = 0;
  int got_pix[$], got_last[$], got_edge[$];
  int exp_pix[$], exp_last[$], exp_edge[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] p, input logic r);
    in_valid = v;
    in_pixel = p;
    reset    = r;
    @(posedge clk);
    edge_n++;
    #1;
    if (out_valid === 1'b1) begin
      got_pix.push_back(int'(out_pixel));
      got_last.push_back(int'(out_last));
      got_edge.push_back(edge_n);
    end
  endtask

  // kind 0: flat 100, kind 1: ramp 10*col, kind 2: step 0|200 at col 2
  function automatic logic [7:0] pix(input int kind, input int c);
    case (kind)
      0:       return 8'd100;
      1:       return 8'(10 * c);
      default: return (c < 2) ? 8'd0 : 8'd200;
    endcase
  endfunction

  function automatic int expected_mag(input int kind, input int c);
    case (kind)
      0:       return 0;
      1:       return 80;
      default: return (c <= 3) ? 255 : 0;
    endcase
  endfunction

  task automatic send_frame(input int kind, input bit gapped, input int npix, input bit record);
    int n = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (n < npix) begin
          step(1'b1, pix(kind, c), 1'b0);
          if (record && r >= 2 && c >= 2) begin
            exp_pix.push_back(expected_mag(kind, c));
            exp_last.push_back((r == H - 1 && c == W - 1) ? 1 : 0);
            exp_edge.push_back(edge_n + 2);
          end
          if (gapped) step(1'b0, 8'hAA, 1'b0);
          n++;
        end
      end
    end
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h55, 1'b0);
  endtask

  task automatic check_outputs(input string tag);
    int n;
    chk({tag, "_count"}, got_pix.size(), exp_pix.size());
    n = (got_pix.size() < exp_pix.size()) ? got_pix.size() : exp_pix.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_pix%0d", tag, i), got_pix[i], exp_pix[i]);
      chk($sformatf("%s_last%0d", tag, i), got_last[i], exp_last[i]);
      chk($sformatf("%s_lat%0d", tag, i), got_edge[i], exp_edge[i]);
    end
    got_pix.delete(); got_last.delete(); got_edge.delete();
    exp_pix.delete(); exp_last.delete(); exp_edge.delete();
  endtask

  initial begin
    // reset with in_valid high and a bright pixel: nothing may come out
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'hFF, 1'b1);
      chk("rst_valid", out_valid, 0);
      chk("rst_pixel", out_pixel, 0);
      chk("rst_last", out_last, 0);
    end

    send_frame(0, 1'b0, H * W, 1'b1);
    flush(5);
    check_outputs("flat");

    send_frame(1, 1'b0, H * W, 1'b1);
    flush(5);
    check_outputs("ramp");
    chk("hold_pixel", out_pixel, 80);

    send_frame(2, 1'b0, H * W, 1'b1);
    flush(5);
    check_outputs("vstep");

    send_frame(1, 1'b1, H * W, 1'b1);
    flush(5);
    check_outputs("gapped");

    // back-to-back frames, then abort the third right after its first completing pixel
    send_frame(0, 1'b0, H * W, 1'b1);
    send_frame(1, 1'b0, H * W, 1'b1);
    send_frame(2, 1'b0, 2 * W + 3, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'hFF, 1'b1);
      chk("abort_valid", out_valid, 0);
    end
    flush(3);
    send_frame(2, 1'b0, H * W, 1'b1);
    flush(5);
    check_outputs("b2b_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
